qa_drv_prim_hazard_sched: RTL and testbench

- Schedules memory requests from N_REQ requesters onto one downstream channel.
- Blocks any request whose address hashes to a bucket that already has a request in flight, so same-bucket requests are serialized.
- Holds per-bucket in-flight counts in an internal qa_drv_prim_counting_filter instance: inserts on grant, removes on completion.
- Sits between the QA driver's request muxes and the memory/QPI request path.

---
 rtl/qa_drv_hazard_sched_pkg.sv | 10 +
 rtl/qa_drv_prim_counting_filter.sv | 44 ++++
 rtl/qa_drv_prim_rr_arb.sv | 35 +++
 rtl/qa_drv_prim_hazard_sched.sv | 119 +++++++++++
 tb/tb_qa_drv_prim_hazard_sched.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/qa_drv_hazard_sched_pkg.sv
// qa_drv_hazard_sched_pkg: shared widths, bucket index type and bucket hash for the hazard scheduler.
package qa_drv_hazard_sched_pkg;
    localparam int BUCKET_IDX_WIDTH = 6;
    localparam int OUTSTANDING_WIDTH = 16;
    typedef logic [BUCKET_IDX_WIDTH-1:0] t_bucket_idx;
    // Folds the two lowest h-bit address fields together; bits at and above h are zero.
    function automatic logic [15:0] bucket_hash(input logic [63:0] addr, input int h);
        return 16'(addr ^ (addr >> h)) & ((16'(1) << h) - 16'(1));
    endfunction
endpackage

// File: rtl/qa_drv_prim_counting_filter.sv
// qa_drv_prim_counting_filter: per-bucket saturating counters with multi-client insert, remove and zero test.
module qa_drv_prim_counting_filter #(
    parameter int N_BUCKETS = 64,
    parameter int BITS_PER_BUCKET = 4,
    parameter int N_INSERT_CLIENTS = 1,
    parameter int N_REMOVE_CLIENTS = 1,
    parameter int N_TEST_CLIENTS = 4,
    localparam int H = $clog2(N_BUCKETS)
) (
    input  logic                                 clk,
    input  logic                                 resetb,
    input  logic [N_INSERT_CLIENTS-1:0]          insert_en_i,
    input  logic [N_INSERT_CLIENTS-1:0][H-1:0]   insert_bucket_i,
    input  logic [N_REMOVE_CLIENTS-1:0]          remove_en_i,
    input  logic [N_REMOVE_CLIENTS-1:0][H-1:0]   remove_bucket_i,
    input  logic [N_TEST_CLIENTS-1:0][H-1:0]     test_bucket_i,
    output logic [N_TEST_CLIENTS-1:0]            test_isZero_o
);
    localparam int CMAX = (1 << BITS_PER_BUCKET) - 1;
    logic [BITS_PER_BUCKET-1:0] cnt_q [N_BUCKETS];
    logic [BITS_PER_BUCKET-1:0] cnt_d [N_BUCKETS];
    int n;
    // Net all clients per bucket before clamping so same-cycle insert and remove cancel.
    always_comb begin
        n = 0;
        for (int b = 0; b < N_BUCKETS; b++) begin
            n = int'(cnt_q[b]);
            for (int c = 0; c < N_INSERT_CLIENTS; c++)
                n = n + int'(insert_en_i[c] && insert_bucket_i[c] == H'(b));
            for (int c = 0; c < N_REMOVE_CLIENTS; c++)
                n = n - int'(remove_en_i[c] && remove_bucket_i[c] == H'(b));
            cnt_d[b] = (n < 0) ? '0 : (n > CMAX) ? '1 : BITS_PER_BUCKET'(n);
        end
    end
    always_comb begin
        test_isZero_o = '0;
        for (int t = 0; t < N_TEST_CLIENTS; t++)
            test_isZero_o[t] = cnt_q[test_bucket_i[t]] == '0;
    end
    always_ff @(posedge clk) begin
        if (!resetb) cnt_q <= '{default: '0};
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/qa_drv_prim_rr_arb.sv
// qa_drv_prim_rr_arb: N-way round-robin arbiter; the pointer moves past the winner on each grant.
module qa_drv_prim_rr_arb #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] j;
    // Scan from farthest to nearest so the requester closest to the pointer is assigned last and wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr_q) + k) % N);
            if (en_i && req_i[j]) begin
                gnt_o = '0;
                gnt_o[j] = 1'b1;
                idx_o = j;
            end
        end
    end
    assign valid_o = |gnt_o;
    always_ff @(posedge clk) begin
        if (!resetb) ptr_q <= '0;
        else if (valid_o) ptr_q <= (idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1;
    end
endmodule

// File: rtl/qa_drv_prim_hazard_sched.sv
// qa_drv_prim_hazard_sched: round-robin scheduler that serializes requests whose address bucket is in flight.
// Defining QA_HAZARD_SCHED_STATS_EN adds saturating hazard-stall and grant counters.
module qa_drv_prim_hazard_sched
    import qa_drv_hazard_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ADDR_WIDTH = 42,
    parameter int N_BUCKETS = 64,
    parameter int BITS_PER_BUCKET = 4,
    parameter int MAX_OUTSTANDING = 32,
    localparam int RW = $clog2(N_REQ),
    localparam int H = $clog2(N_BUCKETS)
) (
    input  logic                                clk,
    input  logic                                resetb,
    input  logic [N_REQ-1:0]                    req_valid,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]    req_addr,
    output logic [N_REQ-1:0]                    req_ready,
    output logic                                out_valid,
    output logic [ADDR_WIDTH-1:0]               out_addr,
    output logic [RW-1:0]                       out_reqId,
    output logic [H-1:0]                        out_bucket,
    input  logic                                out_ready,
    input  logic                                cpl_valid,
    input  logic [H-1:0]                        cpl_bucket,
    output logic [OUTSTANDING_WIDTH-1:0]        outstanding,
`ifdef QA_HAZARD_SCHED_STATS_EN
    output logic [31:0]                         stat_hazardStalls,
    output logic [31:0]                         stat_grants,
`endif
    output logic                                err_underflow
);
    logic [N_REQ-1:0][H-1:0] bucket;
    logic [N_REQ-1:0] zero, elig, gnt;
    logic [RW-1:0] win;
    logic grant, cap_ok, slot_free, cpl_ok;
    logic out_valid_q, err_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [RW-1:0] out_reqId_q;
    logic [H-1:0] out_bucket_q;
    logic [OUTSTANDING_WIDTH-1:0] outstanding_q;
    always_comb begin
        bucket = '0;
        for (int i = 0; i < N_REQ; i++)
            bucket[i] = H'(bucket_hash(64'(req_addr[i]), H));
    end
    assign cap_ok = outstanding_q < OUTSTANDING_WIDTH'(MAX_OUTSTANDING);
    assign elig = req_valid & zero & {N_REQ{cap_ok}};
    assign slot_free = resetb && (!out_valid_q || out_ready);
    // A completion with nothing in flight is an error and must not disturb the filter.
    assign cpl_ok = cpl_valid && outstanding_q != '0;
    qa_drv_prim_rr_arb #(.N(N_REQ)) u_arb (
        .clk(clk),
        .resetb(resetb),
        .req_i(elig),
        .en_i(slot_free),
        .gnt_o(gnt),
        .idx_o(win),
        .valid_o(grant)
    );
    qa_drv_prim_counting_filter #(
        .N_BUCKETS(N_BUCKETS),
        .BITS_PER_BUCKET(BITS_PER_BUCKET),
        .N_INSERT_CLIENTS(1),
        .N_REMOVE_CLIENTS(1),
        .N_TEST_CLIENTS(N_REQ)
    ) u_filter (
        .clk(clk),
        .resetb(resetb),
        .insert_en_i(grant),
        .insert_bucket_i(bucket[win]),
        .remove_en_i(cpl_ok),
        .remove_bucket_i(cpl_bucket),
        .test_bucket_i(bucket),
        .test_isZero_o(zero)
    );
    always_ff @(posedge clk) begin
        if (!resetb) begin
            out_valid_q <= 1'b0;
            out_addr_q <= '0;
            out_reqId_q <= '0;
            out_bucket_q <= '0;
            outstanding_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (grant) begin
                out_valid_q <= 1'b1;
                out_addr_q <= req_addr[win];
                out_reqId_q <= win;
                out_bucket_q <= bucket[win];
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            outstanding_q <= outstanding_q + OUTSTANDING_WIDTH'(grant) - OUTSTANDING_WIDTH'(cpl_ok);
            if (cpl_valid && outstanding_q == '0) err_q <= 1'b1;
        end
    end
    assign req_ready = gnt;
    assign out_valid = out_valid_q;
    assign out_addr = out_addr_q;
    assign out_reqId = out_reqId_q;
    assign out_bucket = out_bucket_q;
    assign outstanding = outstanding_q;
    assign err_underflow = err_q;
`ifdef QA_HAZARD_SCHED_STATS_EN
    logic [31:0] stalls_q, grants_q;
    always_ff @(posedge clk) begin
        if (!resetb) begin
            stalls_q <= '0;
            grants_q <= '0;
        end else begin
            if (|(req_valid & ~zero) && cap_ok && !(&stalls_q)) stalls_q <= stalls_q + 1'b1;
            if (grant && !(&grants_q)) grants_q <= grants_q + 1'b1;
        end
    end
    assign stat_hazardStalls = stalls_q;
    assign stat_grants = grants_q;
`endif
endmodule

// File: tb/tb_qa_drv_prim_hazard_sched.sv
// tb_qa_drv_prim_hazard_sched: directed scoreboard bench for the hazard scheduler.
module tb_qa_drv_prim_hazard_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetb;
    logic [3:0] req_valid, req_ready;
    logic [3:0][41:0] req_addr;
    logic out_valid, out_ready, cpl_valid, err_underflow;
    logic [41:0] out_addr;
    logic [1:0] out_reqId;
    logic [5:0] out_bucket, cpl_bucket;
    logic [15:0] outstanding;
    int n_assert = 0;
    int n_fail = 0;
    typedef struct packed {
        logic [41:0] addr;
        logic [1:0]  id;
        logic [5:0]  bucket;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e, mon_o;

    qa_drv_prim_hazard_sched dut (
        .clk(clk),
        .resetb(resetb),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_addr(out_addr),
        .out_reqId(out_reqId),
        .out_bucket(out_bucket),
        .out_ready(out_ready),
        .cpl_valid(cpl_valid),
        .cpl_bucket(cpl_bucket),
        .outstanding(outstanding),
        .err_underflow(err_underflow)
    );

    function automatic logic [5:0] hash(input logic [41:0] a);
        return a[5:0] ^ a[11:6];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [41:0] a, input int id);
        exp_q.push_back({a, 2'(id), hash(a)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        req_valid = '0;
        cpl_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        resetb = 1'b1;
    endtask

    // Every downstream handshake must match the next predicted grant.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            mon_o = {out_addr, out_reqId, out_bucket};
            mon_e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            n_assert++;
            assert (mon_o === mon_e) else begin
                n_fail++;
                $error("FAIL sb_out: observed 0x%0h expected 0x%0h", mon_o, mon_e);
            end
        end
    end

    initial begin
        resetb = 1'b0;
        req_valid = '0;
        req_addr = '0;
        out_ready = 1'b1;
        cpl_valid = 1'b0;
        cpl_bucket = '0;
        tick();
        req_valid = 4'b0001;
        req_addr[0] = 42'h40;
        tick();
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_req_ready", 64'(req_ready), 0);
        check("rst_outstanding", 64'(outstanding), 0);
        check("rst_err", 64'(err_underflow), 0);
        // single uncontended request, then same bucket blocked next cycle
        resetb = 1'b1;
        #1;
        check("t1_ready", 64'(req_ready), 64'b0001);
        push(42'h40, 0);
        tick();
        req_valid = 4'b0010;
        req_addr[1] = 42'h40;
        #1;
        check("t1_out_valid", 64'(out_valid), 1);
        check("t1_outstanding", 64'(outstanding), 1);
        check("t1_same_bucket_blocked", 64'(req_ready), 0);
        tick();
        check("t1_idle", 64'(out_valid), 0);
        do_reset();
        #1;
        check("t2_mid_reset_outstanding", 64'(outstanding), 0);
        // two requesters on distinct buckets, then a third blocked until completion
        req_addr[0] = 42'h41;
        req_addr[1] = 42'h01;
        req_valid = 4'b0011;
        #1;
        check("t2_gnt0", 64'(req_ready), 64'b0001);
        push(42'h41, 0);
        tick();
        req_valid = 4'b0010;
        #1;
        check("t2_gnt1", 64'(req_ready), 64'b0010);
        check("t2_id0", 64'(out_reqId), 0);
        push(42'h01, 1);
        tick();
        req_valid = 4'b0100;
        req_addr[2] = 42'h000;
        #1;
        check("t2_blocked", 64'(req_ready), 0);
        check("t2_outstanding", 64'(outstanding), 2);
        tick();
        check("t2_still_blocked", 64'(req_ready), 0);
        cpl_valid = 1'b1;
        cpl_bucket = 6'd0;
        #1;
        check("t2_cpl_not_visible", 64'(req_ready), 0);
        tick();
        cpl_valid = 1'b0;
        #1;
        check("t2_gnt2", 64'(req_ready), 64'b0100);
        check("t2_after_cpl", 64'(outstanding), 1);
        push(42'h000, 2);
        tick();
        req_valid = '0;
        #1;
        check("t2_out_valid2", 64'(out_valid), 1);
        check("t2_id2", 64'(out_reqId), 2);
        check("t2_outstanding2", 64'(outstanding), 2);
        tick();
        do_reset();
        // all four requesters, distinct buckets, back-to-back round robin
        req_addr = {42'h400, 42'h300, 42'h200, 42'h100};
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t3_rr", 64'(req_ready), 64'(1) << i);
            push(req_addr[i], i);
            tick();
            req_valid[i] = 1'b0;
        end
        check("t3_outstanding", 64'(outstanding), 4);
        check("t3_last_id", 64'(out_reqId), 3);
        // downstream stall holds the output and blocks grants
        out_ready = 1'b0;
        req_addr[0] = 42'h500;
        req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t4_no_ready", 64'(req_ready), 0);
            check("t4_addr_hold", 64'(out_addr), 64'h400);
            check("t4_id_hold", 64'(out_reqId), 3);
            check("t4_outstanding", 64'(outstanding), 4);
            tick();
        end
        out_ready = 1'b1;
        cpl_valid = 1'b1;
        cpl_bucket = 6'd4;
        #1;
        check("t4_release_gnt", 64'(req_ready), 64'b0001);
        push(42'h500, 0);
        tick();
        req_valid = '0;
        cpl_valid = 1'b0;
        #1;
        check("t4_grant_cpl_net", 64'(outstanding), 4);
        tick();
        do_reset();
        // global in-flight limit
        for (int k = 0; k < 32; k++) begin
            req_valid = 4'b0001;
            req_addr[0] = 42'(k);
            #1;
            check("t5_fill", 64'(req_ready), 64'b0001);
            push(42'(k), 0);
            tick();
        end
        req_addr[0] = 42'd32;
        #1;
        check("t5_full", 64'(outstanding), 32);
        check("t5_cap_blocked", 64'(req_ready), 0);
        tick();
        check("t5_cap_blocked2", 64'(req_ready), 0);
        cpl_valid = 1'b1;
        cpl_bucket = 6'd0;
        #1;
        check("t5_cap_blocked3", 64'(req_ready), 0);
        tick();
        cpl_valid = 1'b0;
        #1;
        check("t5_after_cpl", 64'(outstanding), 31);
        check("t5_gnt33", 64'(req_ready), 64'b0001);
        push(42'd32, 0);
        tick();
        req_valid = '0;
        #1;
        check("t5_refull", 64'(outstanding), 32);
        tick();
        do_reset();
        // underflow is sticky until reset
        cpl_valid = 1'b1;
        cpl_bucket = 6'd3;
        tick();
        cpl_valid = 1'b0;
        check("t6_err", 64'(err_underflow), 1);
        check("t6_outstanding", 64'(outstanding), 0);
        tick();
        check("t6_err_sticky", 64'(err_underflow), 1);
        resetb = 1'b0;
        tick();
        check("t6_err_cleared", 64'(err_underflow), 0);
        resetb = 1'b1;
        tick();
        check("sb_drained", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
